// File: rtl/id_stage_pkg.sv
// Shared decode encodings for the ID stage: opcodes, operand-mux selects,
// next-pc selects, ALU control codes and the registered stage payload.
package id_stage_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h01;
  localparam logic [5:0] OP_ANDI  = 6'h02;
  localparam logic [5:0] OP_ORI   = 6'h03;
  localparam logic [5:0] OP_LW    = 6'h04;
  localparam logic [5:0] OP_SW    = 6'h05;
  localparam logic [5:0] OP_BEQ   = 6'h06;
  localparam logic [5:0] OP_BNE   = 6'h07;
  localparam logic [5:0] OP_J     = 6'h08;
  localparam logic [5:0] OP_JR    = 6'h0A;
  localparam logic [5:0] OP_RET   = 6'h0B;

  typedef enum logic [1:0] {A_PC = 2'd0, A_PC1 = 2'd1, A_REG = 2'd2, A_ZERO = 2'd3} a_sel_t;
  typedef enum logic [1:0] {B_IMM = 2'd0, B_REG = 2'd1, B_IMM4 = 2'd2, B_ZERO = 2'd3} b_sel_t;
  typedef enum logic [2:0] {PC_SEQ = 3'd0, PC_BR = 3'd1, PC_JMP = 3'd2, PC_JR = 3'd3,
                            PC_STK = 3'd4} pc_sel_t;
  typedef enum logic [2:0] {ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR = 3'd3,
                            ALU_FUNC = 3'd4, ALU_BRCMP = 3'd5} alu_t;

  // Everything the stage register holds; an all-zero value is a bubble.
  typedef struct packed {
    logic        valid;
    logic [1:0]  a_sel;
    logic [1:0]  b_sel;
    logic [2:0]  pc_sel;
    logic [2:0]  alu;
    logic [5:0]  func;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic [31:0] pc;
    logic [31:0] pc_1;
    logic [31:0] imm;
    logic [31:0] imm4;
  } id_out_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/id_stage_control.sv
// Combinational instruction decoder: operand/pc selects, ALU control,
// source-register usage for hazard detection and immediate generation.
module control_decoder
  import id_stage_pkg::*;
(
  input  logic [31:0] instr,
  output logic [1:0]  a_sel,
  output logic [1:0]  b_sel,
  output logic [2:0]  alu,
  output logic [5:0]  func,
  output logic [2:0]  pc_sel,
  output logic        illegal,
  output logic        uses_rs,
  output logic        uses_rt,
  output logic [31:0] imm,
  output logic [31:0] imm4
);

  logic [5:0] op;
  assign op = instr[31:26];

  always_comb begin
    a_sel   = A_ZERO;
    b_sel   = B_ZERO;
    alu     = ALU_ADD;
    func    = 6'd0;
    pc_sel  = PC_SEQ;
    illegal = 1'b0;
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    case (op)
      OP_RTYPE: begin
        a_sel = A_REG; b_sel = B_REG; alu = ALU_FUNC; func = instr[5:0];
        uses_rs = 1'b1; uses_rt = 1'b1;
      end
      OP_ADDI, OP_LW: begin
        a_sel = A_REG; b_sel = B_IMM; uses_rs = 1'b1;
      end
      OP_SW: begin
        a_sel = A_REG; b_sel = B_IMM; uses_rs = 1'b1; uses_rt = 1'b1;
      end
      OP_ANDI: begin
        a_sel = A_REG; b_sel = B_IMM; alu = ALU_AND; uses_rs = 1'b1;
      end
      OP_ORI: begin
        a_sel = A_REG; b_sel = B_IMM; alu = ALU_OR; uses_rs = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        a_sel = A_REG; b_sel = B_REG; alu = ALU_BRCMP; pc_sel = PC_BR;
        uses_rs = 1'b1; uses_rt = 1'b1;
      end
      OP_J: begin
        a_sel = A_ZERO; b_sel = B_IMM; pc_sel = PC_JMP;
      end
      OP_JR: begin
        a_sel = A_REG; b_sel = B_ZERO; pc_sel = PC_JR; uses_rs = 1'b1;
      end
      OP_RET: begin
        a_sel = A_ZERO; b_sel = B_ZERO; pc_sel = PC_STK;
      end
      default: illegal = 1'b1;
    endcase
  end

  // J carries an unsigned 26-bit target; everything else a signed 16-bit offset.
  always_comb begin
    imm  = (op == OP_J) ? {6'd0, instr[25:0]} : sext16(instr[15:0]);
    imm4 = 32'($signed(imm) >>> 2);
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: one register stage between fetch and EX, with load-use
// bubble insertion, hold/flush handling and a sticky illegal-opcode flag.
module id_stage
  import id_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] pc_1,
  input  logic        instr_valid,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        hold,
  input  logic        flush,
  output logic [31:0] data_a,
  output logic [31:0] data_b,
  output logic [31:0] pc_out,
  output logic [31:0] pc_1_out,
  output logic [31:0] immediate,
  output logic [31:0] immediate_div_4,
  output logic [1:0]  data_a_select,
  output logic [1:0]  data_b_select,
  output logic [2:0]  pc_select,
  output logic [2:0]  alu_control,
  output logic [5:0]  func,
  output logic        out_valid,
  output logic        stall_req,
  output logic        illegal_op
);

  logic [1:0]  dec_a_sel, dec_b_sel;
  logic [2:0]  dec_alu, dec_pc_sel;
  logic [5:0]  dec_func;
  logic        dec_illegal, dec_uses_rs, dec_uses_rt;
  logic [31:0] dec_imm, dec_imm4;

  control_decoder u_dec (
    .instr   (instr),
    .a_sel   (dec_a_sel),
    .b_sel   (dec_b_sel),
    .alu     (dec_alu),
    .func    (dec_func),
    .pc_sel  (dec_pc_sel),
    .illegal (dec_illegal),
    .uses_rs (dec_uses_rs),
    .uses_rt (dec_uses_rt),
    .imm     (dec_imm),
    .imm4    (dec_imm4)
  );

  logic [4:0] rs, rt;
  assign rs = instr[25:21];
  assign rt = instr[20:16];

  id_out_t    q, d_load;
  logic       prev_load;
  logic [4:0] prev_rt;

  // r0 never creates a dependence, so prev_rt==0 suppresses the stall.
  assign stall_req = instr_valid && prev_load && (prev_rt != 5'd0) &&
                     ((dec_uses_rs && (rs == prev_rt)) || (dec_uses_rt && (rt == prev_rt)));

  always_comb begin
    d_load        = '0;
    d_load.valid  = 1'b1;
    d_load.a_sel  = dec_a_sel;
    d_load.b_sel  = dec_b_sel;
    d_load.pc_sel = dec_pc_sel;
    d_load.alu    = dec_alu;
    d_load.func   = dec_func;
    d_load.data_a = rs_data;
    d_load.data_b = rt_data;
    d_load.pc     = pc;
    d_load.pc_1   = pc_1;
    d_load.imm    = dec_imm;
    d_load.imm4   = dec_imm4;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q          <= '0;
      prev_load  <= 1'b0;
      prev_rt    <= 5'd0;
      illegal_op <= 1'b0;
    end else if (flush) begin
      q         <= '0;
      prev_load <= 1'b0;
      prev_rt   <= 5'd0;
    end else if (hold) begin
      q <= q;
    end else if (stall_req || !instr_valid || dec_illegal) begin
      q         <= '0;
      prev_load <= 1'b0;
      prev_rt   <= 5'd0;
      if (instr_valid && dec_illegal) illegal_op <= 1'b1;
    end else begin
      q         <= d_load;
      prev_load <= (instr[31:26] == OP_LW);
      prev_rt   <= rt;
    end
  end

  assign out_valid       = q.valid;
  assign data_a_select   = q.a_sel;
  assign data_b_select   = q.b_sel;
  assign pc_select       = q.pc_sel;
  assign alu_control     = q.alu;
  assign func            = q.func;
  assign data_a          = q.data_a;
  assign data_b          = q.data_b;
  assign pc_out          = q.pc;
  assign pc_1_out        = q.pc_1;
  assign immediate       = q.imm;
  assign immediate_div_4 = q.imm4;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: a reference decode model predicts each
// cycle's registered outputs and stall_req, queued at drive and popped at output.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr, pc, pc_1, rs_data, rt_data;
  logic        instr_valid, hold, flush;
  logic [31:0] data_a, data_b, pc_out, pc_1_out, immediate, immediate_div_4;
  logic [1:0]  data_a_select, data_b_select;
  logic [2:0]  pc_select, alu_control;
  logic [5:0]  func;
  logic        out_valid, stall_req, illegal_op;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .reset(reset), .instr(instr), .pc(pc), .pc_1(pc_1),
    .instr_valid(instr_valid), .rs_data(rs_data), .rt_data(rt_data),
    .hold(hold), .flush(flush), .data_a(data_a), .data_b(data_b),
    .pc_out(pc_out), .pc_1_out(pc_1_out), .immediate(immediate),
    .immediate_div_4(immediate_div_4), .data_a_select(data_a_select),
    .data_b_select(data_b_select), .pc_select(pc_select),
    .alu_control(alu_control), .func(func), .out_valid(out_valid),
    .stall_req(stall_req), .illegal_op(illegal_op)
  );

  typedef struct packed {
    logic        v;
    logic [1:0]  a, b;
    logic [2:0]  pcs, alu;
    logic [5:0]  fn;
    logic [31:0] da, db, p, p1, imm, imm4;
    logic        ill, urs, urt;
  } exp_t;

  exp_t       sb[$];
  exp_t       m_cur;
  logic       m_pl, m_ill;
  logic [4:0] m_prt;
  logic       last_stall;
  int         n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", tag, obs, exp, $time);
  endtask

  function automatic exp_t model_dec(input logic [31:0] i, input logic [31:0] ra, rb, p, p1);
    exp_t e;
    e = '0;
    e.v = 1'b1; e.da = ra; e.db = rb; e.p = p; e.p1 = p1;
    e.imm  = (i[31:26] == 6'h08) ? {6'd0, i[25:0]} : {{16{i[15]}}, i[15:0]};
    e.imm4 = {{2{e.imm[31]}}, e.imm[31:2]};
    case (i[31:26])
      6'h00: begin e.a = 2; e.b = 1; e.alu = 4; e.fn = i[5:0]; e.urs = 1; e.urt = 1; end
      6'h01, 6'h04: begin e.a = 2; e.b = 0; e.alu = 0; e.urs = 1; end
      6'h05: begin e.a = 2; e.b = 0; e.alu = 0; e.urs = 1; e.urt = 1; end
      6'h02: begin e.a = 2; e.b = 0; e.alu = 2; e.urs = 1; end
      6'h03: begin e.a = 2; e.b = 0; e.alu = 3; e.urs = 1; end
      6'h06, 6'h07: begin e.a = 2; e.b = 1; e.alu = 5; e.pcs = 1; e.urs = 1; e.urt = 1; end
      6'h08: begin e.a = 3; e.b = 0; e.alu = 0; e.pcs = 2; end
      6'h0A: begin e.a = 2; e.b = 3; e.alu = 0; e.pcs = 3; e.urs = 1; end
      6'h0B: begin e.a = 3; e.b = 3; e.alu = 0; e.pcs = 4; end
      default: e.ill = 1;
    endcase
    return e;
  endfunction

  task automatic cmp_out();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk("out_valid", {31'd0, out_valid}, {31'd0, e.v});
    chk("a_sel", {30'd0, data_a_select}, {30'd0, e.a});
    chk("b_sel", {30'd0, data_b_select}, {30'd0, e.b});
    chk("pc_sel", {29'd0, pc_select}, {29'd0, e.pcs});
    chk("alu", {29'd0, alu_control}, {29'd0, e.alu});
    chk("func", {26'd0, func}, {26'd0, e.fn});
    if (e.v) begin
      chk("data_a", data_a, e.da);
      chk("data_b", data_b, e.db);
      chk("pc_out", pc_out, e.p);
      chk("pc_1_out", pc_1_out, e.p1);
      chk("imm", immediate, e.imm);
      chk("imm4", immediate_div_4, e.imm4);
    end
    chk("illegal_op", {31'd0, illegal_op}, {31'd0, m_ill});
  endtask

  task automatic cyc(input logic [31:0] i, input logic v, input logic h, input logic f);
    exp_t d, e;
    logic st;
    @(negedge clk);
    instr = i; instr_valid = v; hold = h; flush = f;
    rs_data = $urandom; rt_data = $urandom; pc = $urandom; pc_1 = pc + 32'd1;
    #1;
    d  = model_dec(i, rs_data, rt_data, pc, pc_1);
    st = v && m_pl && (m_prt != 5'd0) &&
         ((d.urs && i[25:21] == m_prt) || (d.urt && i[20:16] == m_prt));
    last_stall = st;
    chk("stall_req", {31'd0, stall_req}, {31'd0, st});
    if (f) begin
      e = '0; m_pl = 0; m_prt = 0;
    end else if (h) begin
      e = m_cur;
    end else if (st || !v || d.ill) begin
      e = '0; m_pl = 0; m_prt = 0;
      if (v && d.ill) m_ill = 1;
    end else begin
      e = d; m_pl = (i[31:26] == 6'h04); m_prt = i[20:16];
    end
    m_cur = e;
    sb.push_back(e);
    @(posedge clk);
    #1;
    cmp_out();
  endtask

  // Present one instruction, re-presenting it while a load-use stall is predicted.
  task automatic issue(input logic [31:0] i, output int nst);
    nst = 0;
    cyc(i, 1, 0, 0);
    while (last_stall && nst < 4) begin
      nst++;
      cyc(i, 1, 0, 0);
    end
    if (last_stall) chk("stall_timeout", 32'd1, 32'd0);
  endtask

  task automatic model_reset();
    m_cur = '0; m_pl = 0; m_prt = 0; m_ill = 0;
    sb.delete();
  endtask

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  initial begin
    int ns;
    model_reset();
    reset = 1; instr = 0; pc = 0; pc_1 = 0; instr_valid = 0;
    rs_data = 0; rt_data = 0; hold = 0; flush = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_alu", {29'd0, alu_control}, 32'd0);
    chk("rst_imm", immediate, 32'd0);
    chk("rst_stall", {31'd0, stall_req}, 32'd0);
    chk("rst_ill", {31'd0, illegal_op}, 32'd0);
    @(negedge clk); reset = 0;

    // ADDI r2,r1,-8 with literal expectations
    issue(32'h0422FFF8, ns);
    chk("addi_imm", immediate, 32'hFFFFFFF8);
    chk("addi_imm4", immediate_div_4, 32'hFFFFFFFE);
    chk("addi_asel", {30'd0, data_a_select}, 32'd2);

    // Load-use on r3: exactly one stall cycle
    issue(itype(6'h04, 5'd1, 5'd3, 16'd4), ns);
    issue(rtype(5'd3, 5'd5, 5'd4, 6'h20), ns);
    chk("lu_stalls", ns, 32'd1);
    chk("lu_func", {26'd0, func}, 32'h20);

    // Load to r0 never stalls
    issue(itype(6'h04, 5'd1, 5'd0, 16'd8), ns);
    issue(rtype(5'd0, 5'd6, 5'd7, 6'h22), ns);
    chk("r0_stalls", ns, 32'd0);

    // Load then J whose target bits alias rs: J has no source register
    issue(itype(6'h04, 5'd2, 5'd1, 16'd0), ns);
    issue({6'h08, 26'h0200000}, ns);
    chk("j_stalls", ns, 32'd0);
    chk("j_imm", immediate, 32'h00200000);

    // Load then SW through rt
    issue(itype(6'h04, 5'd2, 5'd9, 16'd0), ns);
    issue(itype(6'h05, 5'd4, 5'd9, 16'h8000), ns);
    chk("sw_stalls", ns, 32'd1);

    // Remaining opcodes
    issue(itype(6'h02, 5'd3, 5'd4, 16'h00FF), ns);
    issue(itype(6'h03, 5'd3, 5'd4, 16'hF00F), ns);
    issue(itype(6'h07, 5'd3, 5'd4, 16'hFFF0), ns);
    issue({6'h08, 26'h3FFFFFF}, ns);
    chk("jmax_imm", immediate, 32'h03FFFFFF);
    issue(itype(6'h0A, 5'd8, 5'd0, 16'd0), ns);
    issue(itype(6'h0B, 5'd0, 5'd0, 16'd0), ns);

    // Hold retains, invalid loads a bubble
    issue(itype(6'h01, 5'd5, 5'd6, 16'h1234), ns);
    cyc(itype(6'h03, 5'd1, 5'd1, 16'd1), 1, 1, 0);
    cyc(itype(6'h03, 5'd1, 5'd1, 16'd1), 1, 1, 0);
    cyc(itype(6'h03, 5'd1, 5'd1, 16'd1), 0, 0, 0);

    // BEQ then hold+flush together: flush wins
    issue(itype(6'h06, 5'd1, 5'd2, 16'd3), ns);
    cyc(itype(6'h01, 5'd1, 5'd2, 16'd3), 1, 1, 1);
    chk("flush_pcsel", {29'd0, pc_select}, 32'd0);

    // Illegal opcode is sticky
    cyc({6'h3F, 26'd0}, 1, 0, 0);
    chk("ill_set", {31'd0, illegal_op}, 32'd1);
    issue(itype(6'h01, 5'd1, 5'd2, 16'd5), ns);
    issue(rtype(5'd1, 5'd2, 5'd3, 6'h24), ns);

    // Asynchronous reset between edges during hold
    issue(itype(6'h01, 5'd1, 5'd2, 16'h7FFF), ns);
    @(negedge clk);
    hold = 1;
    #2 reset = 1;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_imm", immediate, 32'd0);
    chk("arst_asel", {30'd0, data_a_select}, 32'd0);
    chk("arst_data_a", data_a, 32'd0);
    chk("arst_ill", {31'd0, illegal_op}, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 0; hold = 0;
    issue(itype(6'h01, 5'd1, 5'd2, 16'd1), ns);
    chk("post_rst_stalls", ns, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
